// File: rtl/cps2_video_pkg.sv
// Shared CPS2 video constants, pixel/control layouts and the arithmetic helpers
// used by the line-buffer scan-out path.
`timescale 1ns/1ps
package cps2_video_pkg;

   localparam int unsigned H_PIXELS  = 384;
   localparam int unsigned NUM_LBUF  = 40;
   localparam int unsigned LBUF_AW   = 14;
   localparam int unsigned V_CTR_MAX = 4;

   typedef struct packed {
      logic [3:0] bri;
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } pixel_t;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       de;
      logic       x_valid;
      logic [2:0] v_ctr;
   } ctl_t;

   // Row stride of 384 = 256 + 128; illegal rows fall back to row 0.
   function automatic logic [LBUF_AW-1:0] lbuf_addr(input logic [5:0] vcnt,
                                                    input logic [8:0] hcnt);
      logic [5:0] row;
      row = (vcnt < 6'(NUM_LBUF)) ? vcnt : 6'd0;
      return {row, 8'd0} + {1'b0, row, 7'd0} + 14'(hcnt);
   endfunction

   function automatic logic [7:0] chan_decode(input logic [3:0] c4, input logic [3:0] bri);
      logic [12:0] prod;
      prod = 13'({c4, c4}) * 13'({1'b0, bri} + 5'd16);
      return prod[12:5];
   endfunction

   function automatic logic [7:0] scanline_dim(input logic [7:0] c8, input logic [1:0] str);
      logic [1:0] sh;
      sh = 2'd3 - str;
      return (str == 2'd3) ? 8'd0 : c8 - (c8 >> sh);
   endfunction

endpackage

// File: rtl/cps2_color_decode.sv
// One registered stage turning a CPS2 brightness/RGB444 word into RGB888.
`timescale 1ns/1ps
module cps2_color_decode
   import cps2_video_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] pix,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b
);

   pixel_t p;
   assign p = pixel_t'(pix);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r <= '0;
         g <= '0;
         b <= '0;
      end else begin
         r <= chan_decode(p.r, p.bri);
         g <= chan_decode(p.g, p.bri);
         b <= chan_decode(p.b, p.bri);
      end
   end

endmodule

// File: rtl/lbuf_scanout.sv
// Line-buffer scan-out: RAM addressing, colour decode, blanking/scanlines and
// sync/DE delay so everything leaves RAM_LATENCY+3 cycles after it arrived.
`timescale 1ns/1ps
module lbuf_scanout
   import cps2_video_pkg::*;
#(
   parameter int unsigned RAM_LATENCY = 2
) (
   input  logic                 PCLK,
   input  logic                 reset_n,
   input  logic                 HSYNC_in,
   input  logic                 VSYNC_in,
   input  logic                 DE_in,
   input  logic [8:0]           hcnt_lbuf,
   input  logic [5:0]           vcnt_lbuf,
   input  logic [2:0]           v_ctr,
   input  logic [2:0]           sl_cfg,
   output logic [LBUF_AW-1:0]   rd_addr,
   input  logic [15:0]          rd_data,
   output logic [7:0]           R_out,
   output logic [7:0]           G_out,
   output logic [7:0]           B_out,
   output logic                 HSYNC_out,
   output logic                 VSYNC_out,
   output logic                 DE_out
);

   // Control must line up with the decode register: address stage + RAM + decode.
   localparam int unsigned DLY = RAM_LATENCY + 2;

   ctl_t       dly_q [DLY];
   ctl_t       ctl_in;
   ctl_t       ctl_d;
   logic       sl_en_l;
   logic [1:0] str_l;
   logic [7:0] dec_r, dec_g, dec_b;
   logic [7:0] r_d, g_d, b_d;

   assign ctl_in = '{hs: HSYNC_in, vs: VSYNC_in, de: DE_in,
                     x_valid: (hcnt_lbuf < 9'(H_PIXELS)), v_ctr: v_ctr};
   assign ctl_d  = dly_q[DLY-1];

   always_ff @(posedge PCLK or negedge reset_n) begin
      if (!reset_n) begin
         rd_addr <= '0;
         for (int i = 0; i < int'(DLY); i++) dly_q[i] <= '0;
      end else begin
         rd_addr  <= lbuf_addr(vcnt_lbuf, hcnt_lbuf);
         dly_q[0] <= ctl_in;
         for (int i = 1; i < int'(DLY); i++) dly_q[i] <= dly_q[i-1];
      end
   end

   // Unreset on purpose: only meaningful once a vsync has loaded it.
   always_ff @(posedge PCLK) begin
      if (!VSYNC_in) begin
         sl_en_l <= sl_cfg[0];
         str_l   <= sl_cfg[2:1];
      end
   end

   cps2_color_decode u_decode (
      .clk   (PCLK),
      .rst_n (reset_n),
      .pix   (rd_data),
      .r     (dec_r),
      .g     (dec_g),
      .b     (dec_b)
   );

   always_comb begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
      if (ctl_d.de && ctl_d.x_valid) begin
         if (sl_en_l && (ctl_d.v_ctr == 3'(V_CTR_MAX))) begin
            r_d = scanline_dim(dec_r, str_l);
            g_d = scanline_dim(dec_g, str_l);
            b_d = scanline_dim(dec_b, str_l);
         end else begin
            r_d = dec_r;
            g_d = dec_g;
            b_d = dec_b;
         end
      end
   end

   always_ff @(posedge PCLK or negedge reset_n) begin
      if (!reset_n) begin
         R_out     <= '0;
         G_out     <= '0;
         B_out     <= '0;
         HSYNC_out <= 1'b0;
         VSYNC_out <= 1'b0;
         DE_out    <= 1'b0;
      end else begin
         R_out     <= r_d;
         G_out     <= g_d;
         B_out     <= b_d;
         HSYNC_out <= ctl_d.hs;
         VSYNC_out <= ctl_d.vs;
         DE_out    <= ctl_d.de;
      end
   end

endmodule

// File: tb/tb_lbuf_scanout.sv
// Scoreboard bench for lbuf_scanout: directed vectors push expectations, a
// monitor pops and compares them on the cycle the DUT should present them.
`timescale 1ns/1ps
module tb_lbuf_scanout;

   localparam int LAT = 5;

   logic        PCLK = 1'b0;
   logic        reset_n = 1'b0;
   logic        HSYNC_in, VSYNC_in, DE_in;
   logic [8:0]  hcnt_lbuf;
   logic [5:0]  vcnt_lbuf;
   logic [2:0]  v_ctr, sl_cfg;
   logic [13:0] rd_addr;
   logic [15:0] rd_data;
   logic [7:0]  R_out, G_out, B_out;
   logic        HSYNC_out, VSYNC_out, DE_out;

   always #5 PCLK = ~PCLK;

   lbuf_scanout #(.RAM_LATENCY(2)) dut (
      .PCLK      (PCLK),
      .reset_n   (reset_n),
      .HSYNC_in  (HSYNC_in),
      .VSYNC_in  (VSYNC_in),
      .DE_in     (DE_in),
      .hcnt_lbuf (hcnt_lbuf),
      .vcnt_lbuf (vcnt_lbuf),
      .v_ctr     (v_ctr),
      .sl_cfg    (sl_cfg),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .R_out     (R_out),
      .G_out     (G_out),
      .B_out     (B_out),
      .HSYNC_out (HSYNC_out),
      .VSYNC_out (VSYNC_out),
      .DE_out    (DE_out)
   );

   // Two-cycle registered RAM model.
   logic [15:0] mem [16384];
   logic [15:0] ram_p0, ram_p1;
   always @(posedge PCLK) begin
      ram_p0 <= mem[rd_addr];
      ram_p1 <= ram_p0;
   end
   assign rd_data = ram_p1;

   typedef struct {
      int          tgt;
      int          id;
      logic [26:0] exp;
   } pix_e_t;

   typedef struct {
      int          tgt;
      int          id;
      logic [13:0] exp;
   } addr_e_t;

   pix_e_t  pix_q[$];
   addr_e_t addr_q[$];
   int      tests = 0;
   int      fails = 0;
   int      cyc = 0;
   int      vec_id = 0;

   always @(posedge PCLK) cyc <= cyc + 1;

   task automatic check(input string name, input int id, input logic [26:0] act,
                        input logic [26:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s vec %0d: got %h want %h", name, id, act, exp);
      end
   endtask

   // Expectation layout: {R, G, B, HSYNC, VSYNC, DE}.
   task automatic step(input logic hs, input logic vs, input logic de, input logic [8:0] h,
                       input logic [5:0] v, input logic [2:0] vc, input logic [23:0] rgb);
      pix_e_t e;
      @(posedge PCLK);
      #1;
      HSYNC_in  = hs;
      VSYNC_in  = vs;
      DE_in     = de;
      hcnt_lbuf = h;
      vcnt_lbuf = v;
      v_ctr     = vc;
      vec_id++;
      e.tgt = cyc + LAT;
      e.id  = vec_id;
      e.exp = {rgb, hs, vs, de};
      pix_q.push_back(e);
   endtask

   task automatic expect_addr(input logic [13:0] a);
      addr_e_t e;
      e.tgt = cyc + 1;
      e.id  = vec_id;
      e.exp = a;
      addr_q.push_back(e);
   endtask

   task automatic idle(input int n, input logic vs);
      for (int i = 0; i < n; i++) step(1'b1, vs, 1'b0, 9'd0, 6'd0, 3'd0, 24'h0);
   endtask

   initial begin : monitor
      pix_e_t  pe;
      addr_e_t ae;
      forever begin
         @(posedge PCLK);
         #3;
         while (pix_q.size() != 0 && pix_q[0].tgt <= cyc) begin
            pe = pix_q.pop_front();
            check("pixel", pe.id, {R_out, G_out, B_out, HSYNC_out, VSYNC_out, DE_out}, pe.exp);
         end
         while (addr_q.size() != 0 && addr_q[0].tgt <= cyc) begin
            ae = addr_q.pop_front();
            check("rd_addr", ae.id, 27'(rd_addr), 27'(ae.exp));
         end
      end
   end

   initial begin : stimulus
      for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
      mem[15359] = 16'hFF00;   // row 39, x 383
      mem[394]   = 16'h0F0F;   // row 1, x 10
      mem[404]   = 16'h8421;   // row 1, x 20
      mem[383]   = 16'hF800;
      mem[384]   = 16'hFFFF;   // visible only if x 384 is not blanked
      mem[464]   = 16'hFFFF;
      mem[511]   = 16'hFFFF;
      mem[0]     = 16'hF0F0;
      mem[7]     = 16'h8421;
      mem[773]   = 16'hFFFF;   // row 2, x 5

      HSYNC_in = 1'b1; VSYNC_in = 1'b1; DE_in = 1'b0;
      hcnt_lbuf = '0; vcnt_lbuf = '0; v_ctr = '0; sl_cfg = 3'b000;

      repeat (3) @(posedge PCLK);
      #2;
      check("reset_outputs", 0, {R_out, G_out, B_out, HSYNC_out, VSYNC_out, DE_out}, 27'h0);
      check("reset_rd_addr", 0, 27'(rd_addr), 27'h0);
      @(posedge PCLK);
      #1 reset_n = 1'b1;

      sl_cfg = 3'b001;
      idle(4, 1'b0);
      idle(6, 1'b1);
      step(1'b0, 1'b1, 1'b0, 9'd0, 6'd0, 3'd0, 24'h0);
      step(1'b0, 1'b1, 1'b0, 9'd0, 6'd0, 3'd0, 24'h0);

      // Isolated DE pulse on the last pixel of the last line buffer.
      step(1'b1, 1'b1, 1'b1, 9'd383, 6'd39, 3'd0, 24'hF70000); expect_addr(14'd15359);
      step(1'b1, 1'b1, 1'b0, 9'd383, 6'd39, 3'd0, 24'h000000);
      step(1'b1, 1'b1, 1'b1, 9'd10,  6'd1,  3'd0, 24'h7F007F); expect_addr(14'd394);
      step(1'b1, 1'b1, 1'b1, 9'd20,  6'd1,  3'd0, 24'h33190C); expect_addr(14'd404);
      step(1'b1, 1'b1, 1'b1, 9'd383, 6'd0,  3'd0, 24'h830000); expect_addr(14'd383);
      step(1'b1, 1'b1, 1'b1, 9'd384, 6'd0,  3'd0, 24'h000000); expect_addr(14'd384);
      step(1'b1, 1'b1, 1'b1, 9'd464, 6'd0,  3'd0, 24'h000000); expect_addr(14'd464);
      step(1'b1, 1'b1, 1'b1, 9'd511, 6'd0,  3'd0, 24'h000000);
      step(1'b1, 1'b1, 1'b1, 9'd0,   6'd0,  3'd0, 24'h00F700); expect_addr(14'd0);
      step(1'b1, 1'b1, 1'b1, 9'd7,   6'd45, 3'd0, 24'h33190C); expect_addr(14'd7);
      step(1'b1, 1'b1, 1'b0, 9'd10,  6'd1,  3'd0, 24'h000000);

      // Scanline, strength 0 latched during the vsync above.
      step(1'b1, 1'b1, 1'b1, 9'd5, 6'd2, 3'd4, 24'hD9D9D9); expect_addr(14'd773);
      step(1'b1, 1'b1, 1'b1, 9'd5, 6'd2, 3'd3, 24'hF7F7F7);
      sl_cfg = 3'b111;
      step(1'b1, 1'b1, 1'b1, 9'd5, 6'd2, 3'd4, 24'hD9D9D9);
      idle(6, 1'b1);
      idle(3, 1'b0);
      idle(6, 1'b1);
      step(1'b1, 1'b1, 1'b1, 9'd5, 6'd2, 3'd4, 24'h000000);
      step(1'b1, 1'b1, 1'b1, 9'd5, 6'd2, 3'd3, 24'hF7F7F7);
      sl_cfg = 3'b011;
      idle(6, 1'b1);
      idle(3, 1'b0);
      idle(6, 1'b1);
      step(1'b1, 1'b1, 1'b1, 9'd5, 6'd2, 3'd4, 24'hBABABA);
      sl_cfg = 3'b010;
      idle(6, 1'b1);
      idle(3, 1'b0);
      idle(6, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 9'd5, 6'd2, 3'd4, 24'hF7F7F7);

      // Reset in the middle of an active line.
      @(posedge PCLK);
      #1 reset_n = 1'b0;
      pix_q.delete();
      addr_q.delete();
      #1;
      check("midline_reset_outputs", vec_id,
            {R_out, G_out, B_out, HSYNC_out, VSYNC_out, DE_out}, 27'h0);
      check("midline_reset_rd_addr", vec_id, 27'(rd_addr), 27'h0);
      repeat (2) @(posedge PCLK);
      #1 reset_n = 1'b1;
      idle(3, 1'b1);
      step(1'b1, 1'b1, 1'b1, 9'd383, 6'd39, 3'd0, 24'hF70000); expect_addr(14'd15359);
      step(1'b0, 1'b1, 1'b0, 9'd383, 6'd39, 3'd0, 24'h000000);
      idle(8, 1'b1);

      for (int i = 0; i < 20 && (pix_q.size() != 0 || addr_q.size() != 0); i++)
         @(posedge PCLK);
      #5;
      tests++;
      if (pix_q.size() != 0 || addr_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d pixel and %0d address expectations left, want 0",
                  pix_q.size(), addr_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
